// File: rtl/keystream_lfsr_gen.sv
// Key-byte source for the XOR/PIPO encrypt stage: a 16-bit Galois LFSR seeded over
// an 8-bit bus, serialised eight bits at a time into key bytes with a valid/take handshake.
module keystream_lfsr_gen #(
    parameter int                  LFSR_W       = 16,
    parameter logic [LFSR_W-1:0]   TAPS         = 16'hB400,
    parameter logic [LFSR_W-1:0]   DEFAULT_SEED = 16'hACE1
) (
    input  logic       clk_bar,
    input  logic       clr_bar,
    input  logic [7:0] seed_in,
    input  logic       seed_ld_lo,
    input  logic       seed_ld_hi,
    input  logic       start,
    input  logic       stop,
    input  logic       key_take,
    output logic [7:0] key_out,
    output logic       key_valid,
    output logic       busy,
    output logic [7:0] byte_count,
    output logic       seed_err
);

    typedef enum logic [1:0] {IDLE, GEN, HOLD} state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [LFSR_W-1:0] r_lfsr;
    logic [7:0]        r_keySr;
    logic [2:0]        r_bitCnt;
    logic [7:0]        r_keyOut;
    logic              r_keyValid;
    logic              r_busy;
    logic [7:0]        r_byteCount;
    logic              r_seedErr;

    logic              w_outBit;
    logic [LFSR_W-1:0] w_lfsrNext;
    logic              w_seedLoad;
    logic              w_startOk;
    logic              w_startZero;
    logic              w_step;
    logic              w_byteDone;
    logic              w_take;
    logic              w_abort;

    assign w_outBit   = r_lfsr[0];
    assign w_lfsrNext = (r_lfsr >> 1) ^ (w_outBit ? TAPS : '0);

    always_ff @(negedge clk_bar or negedge clr_bar) begin
        if (!clr_bar) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // stop beats start in IDLE and beats key_take in HOLD; seeding is only legal in IDLE
    always_comb begin
        w_nextState = r_state;
        w_seedLoad  = 1'b0;
        w_startOk   = 1'b0;
        w_startZero = 1'b0;
        w_step      = 1'b0;
        w_byteDone  = 1'b0;
        w_take      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !stop) begin
                    if (r_lfsr == '0) begin
                        w_startZero = 1'b1;
                    end else begin
                        w_startOk   = 1'b1;
                        w_nextState = GEN;
                    end
                end else begin
                    w_seedLoad = seed_ld_lo | seed_ld_hi;
                end
            end
            GEN: begin
                if (stop) begin
                    w_abort     = 1'b1;
                    w_nextState = IDLE;
                end else begin
                    w_step = 1'b1;
                    if (r_bitCnt == 3'd7) begin
                        w_byteDone  = 1'b1;
                        w_nextState = HOLD;
                    end
                end
            end
            HOLD: begin
                if (stop) begin
                    w_abort     = 1'b1;
                    w_nextState = IDLE;
                end else if (key_take) begin
                    w_take      = 1'b1;
                    w_nextState = GEN;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(negedge clk_bar or negedge clr_bar) begin
        if (!clr_bar) begin
            r_lfsr      <= DEFAULT_SEED;
            r_keySr     <= '0;
            r_bitCnt    <= '0;
            r_keyOut    <= '0;
            r_keyValid  <= 1'b0;
            r_busy      <= 1'b0;
            r_byteCount <= '0;
            r_seedErr   <= 1'b0;
        end else begin
            r_busy <= (w_nextState != IDLE);
            if (w_seedLoad) begin
                if (seed_ld_lo) r_lfsr[7:0]  <= seed_in;
                if (seed_ld_hi) r_lfsr[15:8] <= seed_in;
                r_seedErr <= 1'b0;
            end
            if (w_startZero) r_seedErr <= 1'b1;
            if (w_startOk) begin
                r_seedErr <= 1'b0;
                r_bitCnt  <= '0;
            end
            if (w_step) begin
                r_lfsr   <= w_lfsrNext;
                r_keySr  <= {r_keySr[6:0], w_outBit};
                r_bitCnt <= r_bitCnt + 3'd1;
            end
            // the eighth bit bypasses key_sr so the byte is presented on the same edge
            if (w_byteDone) begin
                r_keyOut    <= {r_keySr[6:0], w_outBit};
                r_keyValid  <= 1'b1;
                r_byteCount <= r_byteCount + 8'd1;
            end
            if (w_take || w_abort) r_keyValid <= 1'b0;
            if (w_abort) r_bitCnt <= '0;
        end
    end

    assign key_out    = r_keyOut;
    assign key_valid  = r_keyValid;
    assign busy       = r_busy;
    assign byte_count = r_byteCount;
    assign seed_err   = r_seedErr;

endmodule

// File: tb/tb_keystream_lfsr_gen.sv
// Self-checking bench for keystream_lfsr_gen: constant vector table, directed
// corner sequences and random stimulus against a bit-queue reference model.
module tb_keystream_lfsr_gen;

    logic       clk_bar;
    logic       clr_bar;
    logic [7:0] seed_in;
    logic       seed_ld_lo;
    logic       seed_ld_hi;
    logic       start;
    logic       stop;
    logic       key_take;
    logic [7:0] key_out;
    logic       key_valid;
    logic       busy;
    logic [7:0] byte_count;
    logic       seed_err;

    int checks = 0;
    int errors = 0;

    keystream_lfsr_gen dut (
        .clk_bar    (clk_bar),
        .clr_bar    (clr_bar),
        .seed_in    (seed_in),
        .seed_ld_lo (seed_ld_lo),
        .seed_ld_hi (seed_ld_hi),
        .start      (start),
        .stop       (stop),
        .key_take   (key_take),
        .key_out    (key_out),
        .key_valid  (key_valid),
        .busy       (busy),
        .byte_count (byte_count),
        .seed_err   (seed_err)
    );

    initial clk_bar = 1'b1;
    always #5 clk_bar = ~clk_bar;

    // downstream XOR/PIPO stage: registers data ^ key when a byte is taken
    logic [7:0] xorData;
    logic [7:0] xorOut;
    always @(negedge clk_bar or negedge clr_bar) begin
        if (!clr_bar) xorOut <= 8'h00;
        else if (key_valid && key_take) xorOut <= xorData ^ key_out;
    end

    // reference model: the generator is either running or not, and collects bits
    // from the polynomial stream into a queue until a full byte is available
    logic [15:0] mLfsr;
    logic [7:0]  mKey;
    logic [7:0]  mCount;
    bit          mValid;
    bit          mRun;
    bit          mErr;
    bit          mBits[$];

    function automatic logic [16:0] galois(input logic [15:0] v);
        logic b;
        b = v[0];
        return {b, (v >> 1) ^ (b ? 16'hB400 : 16'h0000)};
    endfunction

    task automatic resetModel();
        mLfsr  = 16'hACE1;
        mKey   = 8'h00;
        mCount = 8'h00;
        mValid = 1'b0;
        mRun   = 1'b0;
        mErr   = 1'b0;
        mBits.delete();
    endtask

    task automatic modelEdge(input bit st, input bit sp, input bit tk,
                             input bit lo, input bit hi, input logic [7:0] sd);
        logic [16:0] g;
        logic [7:0]  k;
        if (!mRun) begin
            if (st && !sp) begin
                if (mLfsr == 16'h0000) mErr = 1'b1;
                else begin
                    mRun = 1'b1;
                    mErr = 1'b0;
                    mBits.delete();
                end
            end else if (lo || hi) begin
                if (lo) mLfsr[7:0]  = sd;
                if (hi) mLfsr[15:8] = sd;
                mErr = 1'b0;
            end
        end else if (sp) begin
            mRun   = 1'b0;
            mValid = 1'b0;
            mBits.delete();
        end else if (mValid) begin
            if (tk) mValid = 1'b0;
        end else begin
            g     = galois(mLfsr);
            mLfsr = g[15:0];
            mBits.push_back(g[16]);
            if (mBits.size() == 8) begin
                k = 8'h00;
                foreach (mBits[i]) k = {k[6:0], mBits[i]};
                mKey   = k;
                mValid = 1'b1;
                mCount = mCount + 8'd1;
                mBits.delete();
            end
        end
    endtask

    task automatic checkVal(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".key_out"},    {8'h00, key_out},    {8'h00, mKey});
        checkVal({tag, ".key_valid"},  {15'h0, key_valid},  {15'h0, mValid});
        checkVal({tag, ".busy"},       {15'h0, busy},       {15'h0, mRun});
        checkVal({tag, ".byte_count"}, {8'h00, byte_count}, {8'h00, mCount});
        checkVal({tag, ".seed_err"},   {15'h0, seed_err},   {15'h0, mErr});
    endtask

    // drives one set of inputs across one falling edge, then advances the model
    task automatic applyStimulus(input bit st, input bit sp, input bit tk,
                                 input bit lo, input bit hi, input logic [7:0] sd);
        start      = st;
        stop       = sp;
        key_take   = tk;
        seed_ld_lo = lo;
        seed_ld_hi = hi;
        seed_in    = sd;
        @(negedge clk_bar);
        #1;
        modelEdge(st, sp, tk, lo, hi, sd);
    endtask

    task automatic idleEdge(input string tag);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput(tag);
    endtask

    task automatic doReset();
        clr_bar = 1'b0;
        #2;
        resetModel();
        checkOutput("reset");
        clr_bar = 1'b1;
    endtask

    // steps until key_valid rises, returning the number of edges taken
    task automatic waitValid(input string tag, input int limit, output int edges);
        edges = 0;
        while (!key_valid && edges < limit) begin
            idleEdge(tag);
            edges++;
        end
        if (!key_valid) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s.timeout: got key_valid 0 expected 1 within %0d edges", tag, limit);
        end
    endtask

    typedef struct {
        bit         st, sp, tk, lo, hi;
        logic [7:0] sd;
        logic [7:0] eKey;
        bit         eValid, eBusy;
        logic [7:0] eCount;
        bit         eErr;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input bit st, input bit sp, input bit tk, input bit lo, input bit hi,
                          input logic [7:0] sd, input logic [7:0] eKey, input bit eValid,
                          input bit eBusy, input logic [7:0] eCount, input bit eErr);
        vec_t v;
        v.st = st; v.sp = sp; v.tk = tk; v.lo = lo; v.hi = hi; v.sd = sd;
        v.eKey = eKey; v.eValid = eValid; v.eBusy = eBusy; v.eCount = eCount; v.eErr = eErr;
        vecs.push_back(v);
    endtask

    initial begin
        int edges;
        bit st, sp, tk, lo, hi;

        clr_bar    = 1'b1;
        start      = 1'b0;
        stop       = 1'b0;
        key_take   = 1'b0;
        seed_ld_lo = 1'b0;
        seed_ld_hi = 1'b0;
        seed_in    = 8'h00;
        xorData    = 8'h55;
        #1;
        doReset();

        // zero seed is refused, reseed to ACE1, first byte 0x87 eight edges after start
        addVec(0, 0, 0, 1, 1, 8'h00, 8'h00, 0, 0, 8'd0, 0);
        addVec(1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'd0, 1);
        addVec(0, 0, 0, 0, 1, 8'hAC, 8'h00, 0, 0, 8'd0, 0);
        addVec(0, 0, 0, 1, 0, 8'hE1, 8'h00, 0, 0, 8'd0, 0);
        addVec(1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 8'd0, 0);
        for (int i = 0; i < 7; i++) addVec(0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 8'd0, 0);
        addVec(0, 0, 0, 0, 0, 8'h00, 8'h87, 1, 1, 8'd1, 0);
        addVec(0, 0, 1, 0, 0, 8'h00, 8'h87, 0, 1, 8'd1, 0);
        addVec(0, 1, 0, 0, 0, 8'h00, 8'h87, 0, 0, 8'd1, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].st, vecs[i].sp, vecs[i].tk, vecs[i].lo, vecs[i].hi, vecs[i].sd);
            checkVal($sformatf("vec%0d.key_out", i),    {8'h00, key_out},    {8'h00, vecs[i].eKey});
            checkVal($sformatf("vec%0d.key_valid", i),  {15'h0, key_valid},  {15'h0, vecs[i].eValid});
            checkVal($sformatf("vec%0d.busy", i),       {15'h0, busy},       {15'h0, vecs[i].eBusy});
            checkVal($sformatf("vec%0d.byte_count", i), {8'h00, byte_count}, {8'h00, vecs[i].eCount});
            checkVal($sformatf("vec%0d.seed_err", i),   {15'h0, seed_err},   {15'h0, vecs[i].eErr});
        end
        checkVal("vec.lfsr", dut.r_lfsr, 16'hC2C4);

        // seed 0x0001, take immediately, second byte arrives nine edges after the first
        #1;
        doReset();
        applyStimulus(0, 0, 0, 1, 0, 8'h01);
        applyStimulus(0, 0, 0, 0, 1, 8'h00);
        applyStimulus(1, 0, 0, 0, 0, 8'h00);
        checkOutput("seed1.start");
        waitValid("seed1.first", 20, edges);
        checkVal("seed1.latency", 16'(edges), 16'd8);
        checkVal("seed1.key", {8'h00, key_out}, 16'h0080);
        applyStimulus(0, 0, 1, 0, 0, 8'h00);
        checkOutput("seed1.take");
        edges = 1;
        while (!key_valid && edges < 20) begin
            idleEdge("seed1.gap");
            edges++;
        end
        checkVal("seed1.spacing", 16'(edges), 16'd9);

        // stop at GEN edge 4, restart from retained lfsr, start+stop in IDLE does nothing
        #1;
        doReset();
        applyStimulus(1, 0, 0, 0, 0, 8'h00);
        checkOutput("stop.start");
        for (int i = 0; i < 3; i++) idleEdge("stop.gen");
        applyStimulus(0, 1, 0, 0, 0, 8'h00);
        checkOutput("stop.abort");
        applyStimulus(1, 1, 0, 0, 0, 8'h00);
        checkOutput("stop.both");
        applyStimulus(1, 0, 0, 0, 0, 8'h00);
        checkOutput("stop.restart");
        waitValid("stop.byte", 20, edges);
        checkOutput("stop.byte");

        // 20 edges of HOLD without take, then take and clear asynchronously mid-GEN
        for (int i = 0; i < 20; i++) idleEdge("hold");
        applyStimulus(0, 0, 1, 0, 0, 8'h00);
        checkOutput("hold.take");
        for (int i = 0; i < 3; i++) idleEdge("hold.gen");
        #2;
        clr_bar = 1'b0;
        #1;
        checkVal("aclr.key_out",    {8'h00, key_out},    16'h0000);
        checkVal("aclr.key_valid",  {15'h0, key_valid},  16'h0000);
        checkVal("aclr.busy",       {15'h0, busy},       16'h0000);
        checkVal("aclr.byte_count", {8'h00, byte_count}, 16'h0000);
        checkVal("aclr.lfsr",       dut.r_lfsr,          16'hACE1);
        resetModel();
        clr_bar = 1'b1;

        // XOR stage chain and byte_count wrap over 256 takes
        @(negedge clk_bar);
        #1;
        applyStimulus(1, 0, 0, 0, 0, 8'h00);
        for (int n = 0; n < 256; n++) begin
            waitValid("wrap", 20, edges);
            applyStimulus(0, 0, 1, 0, 0, 8'h00);
            checkOutput("wrap.take");
            if (n == 0) checkVal("xor.data_out", {8'h00, xorOut}, 16'h00D2);
        end
        checkVal("wrap.count", {8'h00, byte_count}, 16'h0000);

        // random mix against the model
        #1;
        doReset();
        for (int i = 0; i < 600; i++) begin
            st = ($urandom_range(0, 7) == 0);
            sp = ($urandom_range(0, 19) == 0);
            tk = ($urandom_range(0, 1) == 0);
            lo = !st && ($urandom_range(0, 15) == 0);
            hi = !st && ($urandom_range(0, 15) == 0);
            applyStimulus(st, sp, tk, lo, hi, ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
            checkOutput("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keystream_lfsr_gen.md
Name: keystream_lfsr_gen

Overview:
Upstream key source for the XOR/PIPO encrypt stage. It produces a stream of 8-bit key bytes from a Galois LFSR that is seeded over an 8-bit bus. key_out drives the XOR stage's key input directly. A valid/take handshake lets the consumer pull one fresh key byte per data byte, which turns the static-key path into a stream cipher.

Parameters:
LFSR_W, 16, LFSR width (bits); fixed at 16 for this block
TAPS, 16'hB400, Galois feedback mask (x^16+x^14+x^13+x^11+1)
DEFAULT_SEED, 16'hACE1, LFSR value after reset

Ports:
clk_bar  in  1  system clock; all state updates on its falling edge
clr_bar  in  1  asynchronous active-low clear
seed_in  in  8  seed byte
seed_ld_lo  in  1  load seed_in into lfsr[7:0] (IDLE only)
seed_ld_hi  in  1  load seed_in into lfsr[15:8] (IDLE only)
start  in  1  begin key generation
stop  in  1  abort generation, return to IDLE
key_take  in  1  consumer accepts current key_out
key_out  out  8  current key byte
key_valid  out  1  key_out holds an untaken byte
busy  out  1  high in GEN or HOLD
byte_count  out  8  bytes produced since reset, mod 256
seed_err  out  1  start was refused because lfsr == 0

Behaviour:
- Reset (clr_bar low, async, overrides everything):
  - state = IDLE, lfsr = DEFAULT_SEED, key_sr = 0, bit_cnt = 0.
  - key_out = 0, key_valid = 0, busy = 0, byte_count = 0, seed_err = 0.
- LFSR step:
  - out_bit = lfsr[0]; lfsr <= (lfsr >> 1) ^ (out_bit ? TAPS : 0).
  - key_sr <= {key_sr[6:0], out_bit}, so the first bit generated lands in key_out[7].
- IDLE:
  - seed_ld_lo/seed_ld_hi write their half of lfsr; both high together write seed_in to both halves. Any seed load clears seed_err.
  - start with stop low and lfsr != 0: go to GEN, bit_cnt = 0, seed_err = 0; no LFSR step on this edge.
  - start with lfsr == 0: seed_err = 1, stay in IDLE.
  - start and stop both high: stop wins, stay in IDLE, no flags change.
- GEN:
  - One LFSR step per edge, bit_cnt++.
  - On the edge where bit_cnt = 7: key_out <= {key_sr[6:0], out_bit}, key_valid = 1, byte_count++ (255 wraps to 0), bit_cnt = 0, go to HOLD.
- HOLD:
  - LFSR frozen; key_out and key_valid stable until taken.
  - key_take high: key_valid = 0 on that edge, go to GEN.
  - key_take while key_valid = 0 is ignored (cannot occur in HOLD; ignored in IDLE and GEN).
- Latency and throughput:
  - start sampled at edge N gives key_valid at edge N+8.
  - key_take sampled at edge M gives the next key_valid at edge M+8.
  - Maximum rate is one byte per 9 edges.
- stop in GEN or HOLD: next edge goes to IDLE with key_valid = 0 and bit_cnt = 0.
  - lfsr and key_out are retained; a partial byte is discarded.
  - A later start continues the sequence from the retained lfsr.
- Seed loads in GEN or HOLD are ignored.
- busy = (state != IDLE), registered.
- Reset mid-GEN or mid-HOLD returns to the reset values immediately; no partial byte survives.
- lfsr can never reach 0 from a nonzero seed; the zero check applies only at start.

Test Plan:
1. Reset, then start at edge 0 with no seed load -> key_valid rises at edge 8, key_out = 0x87, internal lfsr = 0xC2C4, byte_count = 1, busy = 1.
2. seed_ld_lo with 0x01 and seed_ld_hi with 0x00, start, then key_take immediately on valid -> first key_out = 0x80 at edge 8, key_valid low for 8 edges, second byte valid 9 edges after the first.
3. Load seed 0x0000 (both halves), start -> seed_err = 1, busy = 0, key_valid = 0. Then load 0xAC (hi) and 0xE1 (lo) -> seed_err = 0; start -> key_out = 0x87.
4. start, stop at GEN edge 4 -> IDLE, key_valid = 0, partial byte discarded. start again -> next byte is generated from the retained lfsr (bench reference-model check); start and stop together in IDLE -> no state change.
5. Hold key_take low for 20 edges in HOLD -> key_out and byte_count unchanged. Assert clr_bar low mid-GEN -> all outputs return to reset values asynchronously, before the next clk_bar edge.
6. Chain with the XOR/PIPO stage, data_in = 0x55 on the first byte -> registered data_out = 0xD2 (0x55 ^ 0x87). Run 256 takes -> byte_count wraps to 0.
